// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared types and helpers for the radix-4 Booth multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_t;

    // Two guard bits are added to the operands, so N+2 bits are recoded two at a time.
    function automatic int booth_iters(input int n);
        return n / 2 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_encoder.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_encoder
// Purpose  : Radix-4 Booth recoder: multiplier triplet to digit select lines.
// Revision : 1.0 - initial release
// ============================================================================
module booth_r4_encoder
    import mult_pkg::*;
(
    input  logic [2:0] i_triplet,
    output logic       o_neg,
    output logic       o_two,
    output logic       o_zero
);

    digit_t w_digit;

    always_comb begin
        w_digit = ZERO;
        case (i_triplet)
            3'b001, 3'b010: w_digit = POS1;
            3'b011:         w_digit = POS2;
            3'b100:         w_digit = NEG2;
            3'b101, 3'b110: w_digit = NEG1;
            default:        w_digit = ZERO;
        endcase
    end

    assign o_neg  = (w_digit == NEG1) || (w_digit == NEG2);
    assign o_two  = (w_digit == POS2) || (w_digit == NEG2);
    assign o_zero = (w_digit == ZERO);

endmodule
`default_nettype wire

// File: rtl/booth_radix4_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : booth_radix4_multiplier
// Purpose  : Sequential radix-4 Booth multiplier, signed or unsigned per op.
// Revision : 1.0 - initial release
// ============================================================================
module booth_radix4_multiplier
    import mult_pkg::*;
#(
    parameter int N = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] Product,
    output logic           ready,
    output logic           busy
);

    localparam int c_W     = N + 2;
    localparam int c_K     = booth_iters(N);
    localparam int c_ACC_W = 2 * c_W + 2;
    localparam int c_CNT_W = $clog2(c_K + 1);

    if ((N < 4) || ((N % 2) != 0)) begin : g_bad_width
        $error("booth_radix4_multiplier: N must be even and at least 4");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_W-1:0]       r_mcand;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_ACC_W-1:0]   w_acc_next;
    logic [c_W-1:0]       w_a_ext;
    logic [c_W-1:0]       w_b_ext;
    logic [c_W:0]         w_mcand_ext;
    logic [c_W:0]         w_pp;
    logic [c_W:0]         adder_output;
    logic                 w_neg;
    logic                 w_two;
    logic                 w_zero;
    logic                 w_accept;
    logic                 w_last;

    assign w_a_ext = signed_mode ? {{2{A[N-1]}}, A} : {2'b00, A};
    assign w_b_ext = signed_mode ? {{2{B[N-1]}}, B} : {2'b00, B};

    // Accumulator layout: {partial sum (W+1), multiplier (W), b[-1]}.
    booth_r4_encoder u_encoder (
        .i_triplet (r_acc[2:0]),
        .o_neg     (w_neg),
        .o_two     (w_two),
        .o_zero    (w_zero)
    );

    assign w_mcand_ext  = {r_mcand[c_W-1], r_mcand};
    assign w_pp         = w_zero ? '0 : (w_two ? {w_mcand_ext[c_W-1:0], 1'b0} : w_mcand_ext);
    assign adder_output = w_neg ? (r_acc[c_ACC_W-1:c_W+1] - w_pp)
                                : (r_acc[c_ACC_W-1:c_W+1] + w_pp);
    assign w_acc_next   = $signed({adder_output, r_acc[c_W:0]}) >>> 2;
    assign w_last       = (r_state == RUN) && (r_count == c_CNT_W'(c_K - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        ready        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_count <= '0;
            Product <= '0;
        end else if (w_accept) begin
            r_mcand <= w_a_ext;
            r_acc   <= {{(c_W + 1){1'b0}}, w_b_ext, 1'b0};
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_acc   <= w_acc_next;
            r_count <= w_last ? '0 : r_count + c_CNT_W'(1);
            // Bits above 2N only carry sign replicas of an in-range product.
            if (w_last) begin
                Product <= w_acc_next[2*N:1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_radix4_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_radix4_multiplier
// Purpose  : Directed and random self-checking bench for the Booth multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_radix4_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit done4  = 1'b0;
    bit done16 = 1'b0;

    logic        rst12, start12, sm12, ready12, busy12;
    logic [11:0] a12, b12;
    logic [23:0] product12;

    logic        rst4, start4, sm4, ready4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;

    logic        rst16, start16, sm16, ready16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] product16;

    booth_radix4_multiplier #(.N(12)) u_dut12 (
        .clk(clk), .rst(rst12), .start(start12), .signed_mode(sm12),
        .A(a12), .B(b12), .Product(product12), .ready(ready12), .busy(busy12)
    );

    booth_radix4_multiplier #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst4), .start(start4), .signed_mode(sm4),
        .A(a4), .B(b4), .Product(product4), .ready(ready4), .busy(busy4)
    );

    booth_radix4_multiplier #(.N(16)) u_dut16 (
        .clk(clk), .rst(rst16), .start(start16), .signed_mode(sm16),
        .A(a16), .B(b16), .Product(product16), .ready(ready16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul(input int n, input bit sm,
                                            input logic [31:0] a, input logic [31:0] b);
        longint av, bv, p;
        av = longint'(a);
        bv = longint'(b);
        if (sm && a[n-1]) av = av - (longint'(1) << n);
        if (sm && b[n-1]) bv = bv - (longint'(1) << n);
        p = av * bv;
        return 64'(p) & ((64'd1 << (2 * n)) - 64'd1);
    endfunction

    task automatic wait_ready12(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (!ready12 && lat < 40) begin
            if (busy12) nbusy++;
            step();
            lat++;
        end
    endtask

    task automatic run12(input bit sm, input logic [11:0] a, input logic [11:0] b,
                         output int lat, output int nbusy);
        sm12    = sm;
        a12     = a;
        b12     = b;
        start12 = 1'b1;
        step();
        start12 = 1'b0;
        wait_ready12(lat, nbusy);
    endtask

    task automatic dir12(input string tag, input bit sm, input logic [11:0] a,
                         input logic [11:0] b, input logic [23:0] exp);
        int lat, nbusy;
        run12(sm, a, b, lat, nbusy);
        check({tag, "_lat"}, lat, 7);
        check(tag, product12, exp);
        step();
        check({tag, "_pulse"}, ready12, 1'b0);
    endtask

    initial begin
        int lat, nbusy;
        logic [11:0] ra, rb;
        bit rs;

        rst12 = 1'b1; start12 = 1'b0; sm12 = 1'b0; a12 = '0; b12 = '0;
        step();
        start12 = 1'b1;
        step();
        start12 = 1'b0;
        check("rst_product", product12, 24'h0);
        check("rst_ready", ready12, 1'b0);
        check("rst_busy", busy12, 1'b0);
        rst12 = 1'b0;
        step();

        // Timing of the first operation: 7 busy cycles, ready one cycle wide.
        run12(1'b1, 12'h800, 12'h800, lat, nbusy);
        check("min_sq_lat", lat, 7);
        check("min_sq_busy", nbusy, 7);
        check("min_sq", product12, 24'h400000);
        check("min_sq_nobusy", busy12, 1'b0);
        step();
        check("min_sq_pulse", ready12, 1'b0);

        dir12("u_max_sq",   1'b0, 12'hFFF, 12'hFFF, 24'hFFE001);
        dir12("s_neg1_sq",  1'b1, 12'hFFF, 12'hFFF, 24'h000001);
        dir12("s_max_min",  1'b1, 12'h7FF, 12'h800, 24'hC00800);
        dir12("s_zero",     1'b1, 12'h000, 12'h123, 24'h000000);
        dir12("u_msb_sq",   1'b0, 12'h800, 12'h800, 24'h400000);
        dir12("u_fff_x1",   1'b0, 12'hFFF, 12'h001, 24'h000FFF);
        dir12("s_fff_x1",   1'b1, 12'hFFF, 12'h001, 24'hFFFFFF);

        // A start pulse while busy must be ignored.
        sm12 = 1'b0; a12 = 12'd3; b12 = 12'd5; start12 = 1'b1;
        step();
        start12 = 1'b0;
        step();
        step();
        a12 = 12'd7; b12 = 12'd7; start12 = 1'b1;
        step();
        start12 = 1'b0;
        wait_ready12(lat, nbusy);
        check("ign_lat", lat, 4);
        check("ign_product", product12, 24'h00000F);
        step();
        check("ign_idle", busy12, 1'b0);

        // Reset in the middle of an operation aborts it.
        sm12 = 1'b1; a12 = 12'h100; b12 = 12'h100; start12 = 1'b1;
        step();
        start12 = 1'b0;
        step();
        step();
        step();
        rst12 = 1'b1;
        step();
        rst12 = 1'b0;
        check("abort_busy", busy12, 1'b0);
        check("abort_ready", ready12, 1'b0);
        check("abort_product", product12, 24'h0);
        step();
        dir12("after_abort", 1'b0, 12'h00A, 12'h00B, 24'h00006E);

        // Back-to-back: new start accepted in the ready cycle.
        run12(1'b1, 12'h7FF, 12'h7FF, lat, nbusy);
        check("b2b_first", product12, 24'h3FF001);
        sm12 = 1'b0; a12 = 12'h123; b12 = 12'h456; start12 = 1'b1;
        step();
        start12 = 1'b0;
        check("b2b_busy", busy12, 1'b1);
        check("b2b_pulse", ready12, 1'b0);
        check("b2b_hold", product12, 24'h3FF001);
        wait_ready12(lat, nbusy);
        check("b2b_lat", lat, 7);
        check("b2b_second", product12, 24'h04EDC2);

        for (int i = 0; i < 1000; i++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            rs = 1'($urandom);
            run12(rs, ra, rb, lat, nbusy);
            check("rnd12_lat", lat, 7);
            check("rnd12", product12, ref_mul(12, rs, 32'(ra), 32'(rb)));
            if ($urandom_range(1) == 0) step();
        end

        for (int i = 0; i < 20000 && !(done4 && done16); i++) step();
        check("rnd_done", {done4, done16}, 2'b11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int lat;
        logic [3:0] ra, rb;
        bit rs;
        rst4 = 1'b1; start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        step();
        step();
        rst4 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rs = 1'($urandom);
            sm4 = rs; a4 = ra; b4 = rb; start4 = 1'b1;
            step();
            start4 = 1'b0;
            lat = 0;
            while (!ready4 && lat < 40) begin
                step();
                lat++;
            end
            check("rnd4_lat", lat, 3);
            check("rnd4", product4, ref_mul(4, rs, 32'(ra), 32'(rb)));
            if ($urandom_range(1) == 0) step();
        end
        done4 = 1'b1;
    end

    initial begin
        int lat;
        logic [15:0] ra, rb;
        bit rs;
        rst16 = 1'b1; start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        step();
        step();
        rst16 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            sm16 = rs; a16 = ra; b16 = rb; start16 = 1'b1;
            step();
            start16 = 1'b0;
            lat = 0;
            while (!ready16 && lat < 40) begin
                step();
                lat++;
            end
            check("rnd16_lat", lat, 9);
            check("rnd16", product16, ref_mul(16, rs, 32'(ra), 32'(rb)));
            if ($urandom_range(1) == 0) step();
        end
        done16 = 1'b1;
    end

endmodule
`default_nettype wire
